// File: rtl/memory_responder_if.sv
// rtl/memory_responder_if.sv - Core-to-memory request/response bus for memory_responder
// master = core side, slave = responder side.
interface memory_responder_if;
    logic [31:0] iAddress;
    logic [31:0] iData;
    logic [1:0]  iSize;
    logic        iUnsigned;
    logic        read;
    logic        write;
    logic [31:0] oData;
    logic        oReady;
    logic        oError;

    modport master (
        output iAddress, iData, iSize, iUnsigned, read, write,
        input  oData, oReady, oError
    );

    modport slave (
        input  iAddress, iData, iSize, iUnsigned, read, write,
        output oData, oReady, oError
    );
endinterface

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - Wait-stated text/data memory responder with byte/half/word access
// Define TEXT_WRITE_EN to make stores into the text region legal.
module memory_responder #(
    parameter logic [31:0] TEXT_BASE   = 32'h0040_0000,
    parameter logic [31:0] DATA_BASE   = 32'h1001_0000,
    parameter int          TEXT_WORDS  = 1024,
    parameter int          DATA_WORDS  = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input logic               clock,
    input logic               reset_n,
    memory_responder_if.slave bus
);
    localparam int TextIdxW = (TEXT_WORDS > 1) ? $clog2(TEXT_WORDS) : 1;
    localparam int DataIdxW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
`ifdef TEXT_WRITE_EN
    localparam bit TextWritable = 1'b1;
`else
    localparam bit TextWritable = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;
    state_t state, nextState;

    logic [31:0] addrReg, dataReg;
    logic [1:0]  sizeReg;
    logic        unsignedReg, readReg, writeReg;
    logic [3:0]  waitCount;
    logic [31:0] respData;
    logic        respError;

    logic [31:0] textMem [TEXT_WORDS];
    logic [31:0] dataMem [DATA_WORDS];

    logic                textHit, dataHit, misaligned, accessError, doWrite;
    logic [TextIdxW-1:0] textIdx;
    logic [DataIdxW-1:0] dataIdx;
    logic [4:0]          laneShift;
    logic [31:0]         curWord, laneWord, laneMask, mergedWord, loadData;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:   if (bus.read | bus.write)
                          nextState = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
            S_WAIT:   if (waitCount <= 4'd1) nextState = S_ACCESS;
            S_ACCESS: nextState = S_DONE;
            default:  nextState = S_IDLE;
        endcase
    end

    // Decode uses 33-bit sums so a region ending at the top of the address space cannot wrap.
    always_comb begin
        textHit = ({1'b0, addrReg} >= {1'b0, TEXT_BASE}) &&
                  ({1'b0, addrReg} <  ({1'b0, TEXT_BASE} + 33'(TEXT_WORDS) * 33'd4));
        dataHit = ({1'b0, addrReg} >= {1'b0, DATA_BASE}) &&
                  ({1'b0, addrReg} <  ({1'b0, DATA_BASE} + 33'(DATA_WORDS) * 33'd4));
        textIdx = TextIdxW'((addrReg - TEXT_BASE) >> 2);
        dataIdx = DataIdxW'((addrReg - DATA_BASE) >> 2);

        misaligned  = ((sizeReg == 2'b01) && addrReg[0]) ||
                      ((sizeReg == 2'b10) && (addrReg[1:0] != 2'b00));
        accessError = (readReg && writeReg) || (sizeReg == 2'b11) || misaligned ||
                      !(textHit || dataHit) || (writeReg && textHit && !TextWritable);
        doWrite     = (state == S_ACCESS) && writeReg && !accessError;

        curWord   = textHit ? textMem[textIdx] : dataMem[dataIdx];
        laneShift = {addrReg[1:0], 3'b000};
        laneWord  = curWord >> laneShift;

        case (sizeReg)
            2'b00: begin
                loadData = {{24{~unsignedReg & laneWord[7]}}, laneWord[7:0]};
                laneMask = 32'h0000_00FF << laneShift;
            end
            2'b01: begin
                loadData = {{16{~unsignedReg & laneWord[15]}}, laneWord[15:0]};
                laneMask = 32'h0000_FFFF << laneShift;
            end
            default: begin
                loadData = curWord;
                laneMask = 32'hFFFF_FFFF;
            end
        endcase
        mergedWord = (curWord & ~laneMask) | ((dataReg << laneShift) & laneMask);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addrReg     <= '0;
            dataReg     <= '0;
            sizeReg     <= '0;
            unsignedReg <= 1'b0;
            readReg     <= 1'b0;
            writeReg    <= 1'b0;
            waitCount   <= '0;
            respData    <= '0;
            respError   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.read | bus.write) begin
                    addrReg     <= bus.iAddress;
                    dataReg     <= bus.iData;
                    sizeReg     <= bus.iSize;
                    unsignedReg <= bus.iUnsigned;
                    readReg     <= bus.read;
                    writeReg    <= bus.write;
                    waitCount   <= 4'(WAIT_CYCLES);
                end
                S_WAIT: waitCount <= waitCount - 4'd1;
                S_ACCESS: begin
                    respData  <= (accessError || writeReg) ? '0 : loadData;
                    respError <= accessError;
                end
                default: ;
            endcase
        end
    end

    // Arrays keep their contents through reset; an aborted access never reaches ACCESS.
    always_ff @(posedge clock) begin
        if (doWrite) begin
            if (textHit) textMem[textIdx] <= mergedWord;
            else         dataMem[dataIdx] <= mergedWord;
        end
    end

    always_comb begin
        bus.oReady = (state == S_DONE);
        bus.oData  = (state == S_DONE) ? respData : '0;
        bus.oError = (state == S_DONE) && respError;
    end
endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - Randomized bench for memory_responder against a byte-level model
module tb_memory_responder;
    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE = 32'h1001_0000;
    localparam int          WORDS     = 1024;
    localparam int          WIN       = 16;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    memory_responder_if busSlow();
    memory_responder_if busFast();

    memory_responder #(.TEXT_BASE(TEXT_BASE), .DATA_BASE(DATA_BASE), .TEXT_WORDS(WORDS),
                       .DATA_WORDS(WORDS), .WAIT_CYCLES(2))
        dutSlow (.clock(clock), .reset_n(reset_n), .bus(busSlow));
    memory_responder #(.TEXT_BASE(TEXT_BASE), .DATA_BASE(DATA_BASE), .TEXT_WORDS(WORDS),
                       .DATA_WORDS(WORDS), .WAIT_CYCLES(0))
        dutFast (.clock(clock), .reset_n(reset_n), .bus(busFast));

    int compared = 0;
    int mismatched = 0;
    logic [31:0] modelSlow [WIN];
    logic [31:0] modelFast [WIN];

    task automatic setBus(input bit fast, input logic [31:0] addr, data, input logic [1:0] size,
                          input logic uns, rd, wr);
        if (fast) begin
            busFast.iAddress = addr; busFast.iData = data; busFast.iSize = size;
            busFast.iUnsigned = uns; busFast.read = rd; busFast.write = wr;
        end else begin
            busSlow.iAddress = addr; busSlow.iData = data; busSlow.iSize = size;
            busSlow.iUnsigned = uns; busSlow.read = rd; busSlow.write = wr;
        end
    endtask

    // Inputs are scrambled right after the accept edge; the response must not notice.
    task automatic doAccess(input bit fast, input logic [31:0] addr, data, input logic [1:0] size,
                            input logic uns, rd, wr,
                            output logic [31:0] rdata, output logic err, output int lat);
        bit seen = 0;
        @(negedge clock);
        setBus(fast, addr, data, size, uns, rd, wr);
        lat = 0; rdata = '0; err = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clock); #1;
            lat++;
            if (lat == 1) setBus(fast, addr ^ 32'h4, ~data, ~size, ~uns, 1'b0, 1'b0);
            @(negedge clock);
            if (fast ? busFast.oReady : busSlow.oReady) begin
                seen = 1;
                rdata = fast ? busFast.oData : busSlow.oData;
                err = fast ? busFast.oError : busSlow.oError;
            end
        end
        if (!seen) begin
            compared++; mismatched++;
            $display("FAIL timeout addr=%h: oReady never seen, required within 40 cycles", addr);
        end
    endtask

    // Little-endian byte model of the data window; predicts the response and updates memory.
    task automatic refModel(input bit fast, input logic [31:0] addr, data, input logic [1:0] size,
                            input logic uns, rd, wr,
                            output logic [31:0] expData, output logic expErr);
        int nb, off, idx;
        logic [31:0] word, val;
        bit inData;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off = int'(addr % 4);
        inData = (addr >= DATA_BASE) && ((addr - DATA_BASE) < 32'(4 * WORDS));
        expErr = (rd && wr) || (size == 2'd3) || ((addr % nb) != 0) || !inData;
        expData = '0;
        if (expErr) return;
        idx = int'((addr - DATA_BASE) / 4);
        if (idx >= WIN) return;
        word = fast ? modelFast[idx] : modelSlow[idx];
        if (wr) begin
            for (int k = 0; k < nb; k++) word[8*(off+k) +: 8] = data[8*k +: 8];
            if (fast) modelFast[idx] = word; else modelSlow[idx] = word;
        end else begin
            val = '0;
            for (int k = 0; k < nb; k++) val[8*k +: 8] = word[8*(off+k) +: 8];
            if (!uns && nb < 4 && val[8*nb-1])
                for (int k = nb; k < 4; k++) val[8*k +: 8] = 8'hFF;
            expData = val;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        setBus(0, '0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
        setBus(1, '0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        compared++;
        if ({busSlow.oReady, busSlow.oError, busSlow.oData} !== 34'b0) begin
            mismatched++;
            $display("FAIL reset_slow: got rdy=%b err=%b data=%h, required all zero",
                     busSlow.oReady, busSlow.oError, busSlow.oData);
        end
        compared++;
        if ({busFast.oReady, busFast.oError, busFast.oData} !== 34'b0) begin
            mismatched++;
            $display("FAIL reset_fast: got rdy=%b err=%b data=%h, required all zero",
                     busFast.oReady, busFast.oError, busFast.oData);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_init;
        logic [31:0] d, ed, v; logic e, ee; int l;
        for (int i = 0; i < WIN; i++) begin
            for (int f = 0; f < 2; f++) begin
                v = $urandom;
                if (i == 1) v = ~((f == 1) ? modelFast[0] : modelSlow[0]);
                refModel(f[0], DATA_BASE + 32'(4*i), v, 2'd2, 1'b0, 1'b0, 1'b1, ed, ee);
                doAccess(f[0], DATA_BASE + 32'(4*i), v, 2'd2, 1'b0, 1'b0, 1'b1, d, e, l);
                compared++;
                if (e !== 1'b0 || d !== 32'h0) begin
                    mismatched++;
                    $display("FAIL init_write[%0d/%0d]: got err=%b data=%h, required 0/0", i, f, e, d);
                end
            end
        end
    endtask

    task automatic test_word;
        logic [31:0] d, ed; logic e, ee; int l;
        refModel(0, 32'h1001_0004, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 1'b1, ed, ee);
        doAccess(0, 32'h1001_0004, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 1'b1, d, e, l);
        compared++;
        if (l !== 4 || e !== 1'b0 || d !== 32'h0) begin
            mismatched++;
            $display("FAIL word_write: got lat=%0d err=%b data=%h, required 4/0/0", l, e, d);
        end
        doAccess(0, 32'h1001_0004, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, d, e, l);
        compared++;
        if (d !== 32'hDEADBEEF || e !== 1'b0) begin
            mismatched++;
            $display("FAIL word_read: got %h err=%b, required deadbeef/0", d, e);
        end
    endtask

    task automatic test_lanes;
        logic [31:0] d, ed; logic e, ee; int l;
        doAccess(0, 32'h1001_0007, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, d, e, l);
        compared++;
        if (d !== 32'hFFFFFFDE) begin
            mismatched++; $display("FAIL byte_signed: got %h, required ffffffde", d);
        end
        doAccess(0, 32'h1001_0007, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0, d, e, l);
        compared++;
        if (d !== 32'h000000DE) begin
            mismatched++; $display("FAIL byte_unsigned: got %h, required 000000de", d);
        end
        refModel(0, 32'h1001_0005, 32'h55, 2'd0, 1'b0, 1'b0, 1'b1, ed, ee);
        doAccess(0, 32'h1001_0005, 32'h55, 2'd0, 1'b0, 1'b0, 1'b1, d, e, l);
        doAccess(0, 32'h1001_0004, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, d, e, l);
        compared++;
        if (d !== 32'hDEAD55EF) begin
            mismatched++; $display("FAIL byte_store: got %h, required dead55ef", d);
        end
        doAccess(0, 32'h1001_0006, 32'h0, 2'd1, 1'b0, 1'b1, 1'b0, d, e, l);
        compared++;
        if (d !== 32'hFFFFDEAD) begin
            mismatched++; $display("FAIL half_signed: got %h, required ffffdead", d);
        end
        doAccess(0, 32'h1001_0004, 32'h0, 2'd1, 1'b0, 1'b1, 1'b0, d, e, l);
        compared++;
        if (d !== 32'h000055EF) begin
            mismatched++; $display("FAIL half_low: got %h, required 000055ef", d);
        end
    endtask

    task automatic test_errors;
        logic [31:0] d; logic e; int l;
        logic [31:0] eAddr [9] = '{32'h1001_0002, 32'h0000_0000, DATA_BASE, DATA_BASE,
                                   DATA_BASE + 32'd4092, DATA_BASE + 32'd4096, DATA_BASE - 32'd1,
                                   TEXT_BASE + 32'd4092, TEXT_BASE + 32'd4096};
        logic [1:0]  eSize [9] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd2, 2'd0, 2'd2, 2'd2};
        logic        eWr   [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        eErr  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            doAccess(0, eAddr[i], 32'h1111_2222, eSize[i], 1'b0, 1'b1, eWr[i], d, e, l);
            compared++;
            if (e !== eErr[i] || (eErr[i] && d !== 32'h0)) begin
                mismatched++;
                $display("FAIL error_case[%0d] addr=%h: got err=%b data=%h, required err=%b",
                         i, eAddr[i], e, d, eErr[i]);
            end
        end
        doAccess(0, 32'h1001_0001, 32'hBEEF, 2'd1, 1'b0, 1'b0, 1'b1, d, e, l);
        compared++;
        if (e !== 1'b1) begin
            mismatched++; $display("FAIL half_misaligned_write: got err=%b, required 1", e);
        end
        doAccess(0, DATA_BASE, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, d, e, l);
        compared++;
        if (d !== modelSlow[0]) begin
            mismatched++; $display("FAIL error_no_change: got %h, required %h", d, modelSlow[0]);
        end
    endtask

    task automatic test_text;
        logic [31:0] d, pre; logic e; int l;
        doAccess(0, TEXT_BASE, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, pre, e, l);
        compared++;
        if (e !== 1'b0) begin
            mismatched++; $display("FAIL text_read_err: got err=%b, required 0", e);
        end
        doAccess(0, TEXT_BASE, 32'h12345678, 2'd2, 1'b0, 1'b0, 1'b1, d, e, l);
        doAccess(0, TEXT_BASE, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, d, e, l);
`ifdef TEXT_WRITE_EN
        compared++;
        if (d !== 32'h12345678) begin
            mismatched++; $display("FAIL text_write: got %h, required 12345678", d);
        end
`else
        compared++;
        if (d !== pre) begin
            mismatched++; $display("FAIL text_protect: got %h, required %h", d, pre);
        end
`endif
    endtask

    task automatic test_random;
        logic [31:0] d, ed, addr, data; logic e, ee, rd, wr, uns; logic [1:0] size; int l, r;
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 19));
            addr = DATA_BASE + 32'($urandom_range(0, 4*WIN-1));
            if (r == 0) addr = 32'h2000_0000 + 32'($urandom_range(0, 255));
            if (r == 1) addr = DATA_BASE - 32'($urandom_range(1, 64));
            size = 2'($urandom_range(0, 2));
            if (r == 2) size = 2'd3;
            wr = 1'($urandom_range(0, 1));
            rd = ~wr;
            if (r == 3) begin rd = 1'b1; wr = 1'b1; end
            uns = 1'($urandom_range(0, 1));
            data = $urandom;
            refModel(0, addr, data, size, uns, rd, wr, ed, ee);
            doAccess(0, addr, data, size, uns, rd, wr, d, e, l);
            compared++;
            if (d !== ed || e !== ee) begin
                mismatched++;
                $display("FAIL random[%0d] addr=%h sz=%0d rd=%b wr=%b: got %h/%b, required %h/%b",
                         n, addr, size, rd, wr, d, e, ed, ee);
            end
        end
    endtask

    task automatic test_handshake;
        @(negedge clock);
        setBus(1, DATA_BASE, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            @(posedge clock);
            @(negedge clock);
            compared++;
            if (busFast.oReady !== ((c % 3) == 2)) begin
                mismatched++;
                $display("FAIL stream_ready[%0d]: got %b, required %b", c, busFast.oReady, (c % 3) == 2);
            end
            if (busFast.oReady) begin
                compared++;
                if (busFast.oData !== modelFast[0]) begin
                    mismatched++;
                    $display("FAIL stream_data[%0d]: got %h, required %h", c, busFast.oData, modelFast[0]);
                end
            end
        end
        setBus(1, '0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_latch;
        logic [31:0] d; logic e; int l;
        doAccess(1, DATA_BASE, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, d, e, l);
        compared++;
        if (d !== modelFast[0] || l !== 2) begin
            mismatched++;
            $display("FAIL latched_addr: got %h lat=%0d, required %h lat=2", d, l, modelFast[0]);
        end
        doAccess(1, DATA_BASE + 32'd8, 32'h3C3C_0F0F, 2'd2, 1'b0, 1'b0, 1'b1, d, e, l);
        modelFast[2] = 32'h3C3C_0F0F;
        doAccess(1, DATA_BASE + 32'd8, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, d, e, l);
        compared++;
        if (d !== modelFast[2]) begin
            mismatched++; $display("FAIL latched_data: got %h, required %h", d, modelFast[2]);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d; logic e; int l;
        @(negedge clock);
        setBus(0, DATA_BASE, 32'hA5A5A5A5, 2'd2, 1'b0, 1'b0, 1'b1);
        @(posedge clock); #1;
        setBus(0, '0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        compared++;
        if ({busSlow.oReady, busSlow.oError, busSlow.oData} !== 34'b0) begin
            mismatched++; $display("FAIL reset_in_wait: outputs not zero (rdy=%b)", busSlow.oReady);
        end
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;
        doAccess(0, DATA_BASE, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, d, e, l);
        compared++;
        if (d !== modelSlow[0] || e !== 1'b0) begin
            mismatched++; $display("FAIL reset_abort_write: got %h, required %h", d, modelSlow[0]);
        end
        // Land in DONE, then pull reset between edges.
        doAccess(0, 32'h1001_0004, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, d, e, l);
        #1 reset_n = 1'b0;
        #1;
        compared++;
        if ({busSlow.oReady, busSlow.oError, busSlow.oData} !== 34'b0) begin
            mismatched++;
            $display("FAIL reset_in_done: got rdy=%b err=%b data=%h, required all zero",
                     busSlow.oReady, busSlow.oError, busSlow.oData);
        end
        @(negedge clock);
        reset_n = 1'b1;
        doAccess(0, 32'h1001_0004, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, d, e, l);
        compared++;
        if (d !== modelSlow[1] || l !== 4) begin
            mismatched++;
            $display("FAIL after_reset: got %h lat=%0d, required %h lat=4", d, l, modelSlow[1]);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_word();
        test_lanes();
        test_errors();
        test_text();
        test_random();
        test_handshake();
        test_latch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
